// File: rtl/enigma_pkg.sv
// Shared types, rotor/reflector wiring tables, notch positions and mod-26 helpers
// for the Enigma cipher core.
package enigma_pkg;

    typedef logic [4:0]        letter_t;
    typedef letter_t [0:25]    wiring_t;
    typedef logic [2:0]        rotor_id_t;

    // Rotor ids 1..5 select I..V; id 0 is reserved for the reflector.
    localparam rotor_id_t ID_REFL = 3'd0;

    typedef enum logic [3:0] {
        S_IDLE, S_STEP,
        S_FWD_R, S_FWD_M, S_FWD_L,
        S_REFL,
        S_BWD_L, S_BWD_M, S_BWD_R,
        S_DONE
    } state_t;

    function automatic wiring_t str_to_wiring(input logic [0:25][7:0] s);
        wiring_t w;
        for (int i = 0; i < 26; i++) w[i] = letter_t'(s[i] - 8'd65);
        return w;
    endfunction

    localparam wiring_t FWD_I   = str_to_wiring("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
    localparam wiring_t FWD_II  = str_to_wiring("AJDKSIRUXBLHWTMCQGZNPYFVOE");
    localparam wiring_t FWD_III = str_to_wiring("BDFHJLCPRTXVZNYEIWGAKMUSQO");
    localparam wiring_t FWD_IV  = str_to_wiring("ESOVPZJAYQUIRHXLNFTGKDCMWB");
    localparam wiring_t FWD_V   = str_to_wiring("VZBRGITYUPSDNHLXAWMJQOFECK");
    localparam wiring_t INV_I   = str_to_wiring("UWYGADFPVZBECKMTHXSLRINQOJ");
    localparam wiring_t INV_II  = str_to_wiring("AJPCZWRLFBDKOTYUQGENHXMIVS");
    localparam wiring_t INV_III = str_to_wiring("TAGBPCSDQEUFVNZHYIXJWLRKOM");
    localparam wiring_t INV_IV  = str_to_wiring("HZWVARTNLGUPXQCEJMBSKDYOIF");
    localparam wiring_t INV_V   = str_to_wiring("QCYLXWENFTZOSMVJUDKGIARPHB");
    localparam wiring_t UKW_B   = str_to_wiring("YRUHQSLDPXNGOKMIEBFZCWVJAT");

    localparam letter_t NOTCH_I   = 5'd16;
    localparam letter_t NOTCH_II  = 5'd4;
    localparam letter_t NOTCH_III = 5'd21;
    localparam letter_t NOTCH_IV  = 5'd9;
    localparam letter_t NOTCH_V   = 5'd25;

    function automatic letter_t notch_of(input rotor_id_t id);
        letter_t n;
        case (id)
            3'd1:    n = NOTCH_I;
            3'd2:    n = NOTCH_II;
            3'd3:    n = NOTCH_III;
            3'd4:    n = NOTCH_IV;
            default: n = NOTCH_V;
        endcase
        return n;
    endfunction

    // sub=0: (a+b) mod 26, sub=1: (a-b) mod 26; inputs are always 0..25.
    function automatic letter_t mod26(input letter_t a, input letter_t b, input logic sub);
        logic [5:0] sum;
        logic [5:0] diff;
        letter_t    r;
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        if (sub) r = diff[5] ? letter_t'(diff + 6'd26) : diff[4:0];
        else     r = (sum >= 6'd26) ? letter_t'(sum - 6'd26) : sum[4:0];
        return r;
    endfunction

    function automatic letter_t wire_lookup(input rotor_id_t id, input logic inv, input letter_t idx);
        wiring_t tab;
        case (id)
            3'd1:    tab = inv ? INV_I   : FWD_I;
            3'd2:    tab = inv ? INV_II  : FWD_II;
            3'd3:    tab = inv ? INV_III : FWD_III;
            3'd4:    tab = inv ? INV_IV  : FWD_IV;
            3'd5:    tab = inv ? INV_V   : FWD_V;
            default: tab = UKW_B;
        endcase
        return (idx < 5'd26) ? tab[idx] : '0;
    endfunction

endpackage

// File: rtl/enigma_if.sv
// Key/load inputs and lamp/position outputs of the cipher core.
interface enigma_if;
    logic [25:0] key;
    logic        key_valid;
    logic        load_en;
    logic [4:0]  load_left;
    logic [4:0]  load_mid;
    logic [4:0]  load_right;
    logic        busy;
    logic [25:0] lamp;
    logic        lamp_valid;
    logic [4:0]  pos_left;
    logic [4:0]  pos_mid;
    logic [4:0]  pos_right;

    modport master (
        output key, key_valid, load_en, load_left, load_mid, load_right,
        input  busy, lamp, lamp_valid, pos_left, pos_mid, pos_right
    );
    modport slave (
        input  key, key_valid, load_en, load_left, load_mid, load_right,
        output busy, lamp, lamp_valid, pos_left, pos_mid, pos_right
    );
endinterface

// File: rtl/enigma_rotor_sub.sv
// Single combinational substitution through one rotor (either direction) or the
// reflector; letter_out = (W[(c+p) mod 26] - p) mod 26.
module rotor_sub
    import enigma_pkg::*;
(
    input  rotor_id_t rotor_id,
    input  logic      inv,
    input  letter_t   pos,
    input  letter_t   letter_in,
    output letter_t   letter_out
);

    letter_t entry;

    always_comb begin
        entry      = mod26(letter_in, pos, 1'b0);
        letter_out = mod26(wire_lookup(rotor_id, inv, entry), pos, 1'b1);
    end

endmodule

// File: rtl/enigma_core.sv
// Enigma engine: one-hot key in, one-hot lamp out 9 edges after accept, one rotor pass per clock.
// No queueing: keys and loads seen while busy are dropped; one letter per 10 cycles.
module enigma_core
    import enigma_pkg::*;
#(
    parameter int ROTOR_L = 1,
    parameter int ROTOR_M = 2,
    parameter int ROTOR_R = 3
) (
    input  logic     CLOCK_50,
    input  logic     resetn,
    enigma_if.slave  eif
);

    localparam rotor_id_t ID_L = rotor_id_t'(ROTOR_L);
    localparam rotor_id_t ID_M = rotor_id_t'(ROTOR_M);
    localparam rotor_id_t ID_R = rotor_id_t'(ROTOR_R);

    state_t      state_q, state_d;
    letter_t     letter_q;
    letter_t     pos_l_q, pos_m_q, pos_r_q;
    logic [25:0] lamp_q;
    logic        lamp_valid_q;

    logic        one_hot, accept, do_load, is_sub;
    letter_t     key_idx;
    rotor_id_t   sub_id;
    logic        sub_inv;
    letter_t     sub_pos, sub_out;

    assign one_hot = (eif.key != '0) && ((eif.key & (eif.key - 26'd1)) == '0);
    assign do_load = (state_q == S_IDLE) && eif.load_en;
    assign accept  = (state_q == S_IDLE) && eif.key_valid && one_hot && !eif.load_en;

    always_comb begin
        key_idx = '0;
        for (int i = 0; i < 26; i++) if (eif.key[i]) key_idx = letter_t'(i);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_STEP;
            S_STEP:  state_d = S_FWD_R;
            S_FWD_R: state_d = S_FWD_M;
            S_FWD_M: state_d = S_FWD_L;
            S_FWD_L: state_d = S_REFL;
            S_REFL:  state_d = S_BWD_L;
            S_BWD_L: state_d = S_BWD_M;
            S_BWD_M: state_d = S_BWD_R;
            S_BWD_R: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Time-share the single substitution unit across the seven pass states.
    always_comb begin
        sub_id  = ID_REFL;
        sub_inv = 1'b0;
        sub_pos = '0;
        is_sub  = 1'b1;
        case (state_q)
            S_FWD_R: begin sub_id = ID_R; sub_pos = pos_r_q; end
            S_FWD_M: begin sub_id = ID_M; sub_pos = pos_m_q; end
            S_FWD_L: begin sub_id = ID_L; sub_pos = pos_l_q; end
            S_REFL:  begin sub_id = ID_REFL; end
            S_BWD_L: begin sub_id = ID_L; sub_pos = pos_l_q; sub_inv = 1'b1; end
            S_BWD_M: begin sub_id = ID_M; sub_pos = pos_m_q; sub_inv = 1'b1; end
            S_BWD_R: begin sub_id = ID_R; sub_pos = pos_r_q; sub_inv = 1'b1; end
            default: is_sub = 1'b0;
        endcase
    end

    rotor_sub u_sub (
        .rotor_id   (sub_id),
        .inv        (sub_inv),
        .pos        (sub_pos),
        .letter_in  (letter_q),
        .letter_out (sub_out)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            letter_q     <= '0;
            pos_l_q      <= '0;
            pos_m_q      <= '0;
            pos_r_q      <= '0;
            lamp_q       <= '0;
            lamp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lamp_valid_q <= (state_q == S_DONE);
            if (do_load) begin
                pos_l_q <= (eif.load_left  >= 5'd26) ? eif.load_left  - 5'd26 : eif.load_left;
                pos_m_q <= (eif.load_mid   >= 5'd26) ? eif.load_mid   - 5'd26 : eif.load_mid;
                pos_r_q <= (eif.load_right >= 5'd26) ? eif.load_right - 5'd26 : eif.load_right;
            end
            if (accept) begin
                letter_q <= key_idx;
                lamp_q   <= '0;
            end
            // Middle steps on its own notch too: the double-step anomaly.
            if (state_q == S_STEP) begin
                pos_r_q <= mod26(pos_r_q, 5'd1, 1'b0);
                if (pos_r_q == notch_of(ID_R) || pos_m_q == notch_of(ID_M))
                    pos_m_q <= mod26(pos_m_q, 5'd1, 1'b0);
                if (pos_m_q == notch_of(ID_M))
                    pos_l_q <= mod26(pos_l_q, 5'd1, 1'b0);
            end
            if (is_sub) letter_q <= sub_out;
            if (state_q == S_DONE) lamp_q <= 26'd1 << letter_q;
        end
    end

    assign eif.busy       = (state_q != S_IDLE);
    assign eif.lamp       = lamp_q;
    assign eif.lamp_valid = lamp_valid_q;
    assign eif.pos_left   = pos_l_q;
    assign eif.pos_mid    = pos_m_q;
    assign eif.pos_right  = pos_r_q;

endmodule

// File: tb/tb_enigma_core.sv
// Directed bench for enigma_core (rotors I-II-III, UKW-B): table-driven key runs plus
// hand-written sequences for load, rejection, busy interference and mid-letter reset.
module tb_enigma_core;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    int   tests = 0;
    int   fails = 0;

    enigma_if bus();

    enigma_core #(.ROTOR_L(1), .ROTOR_M(2), .ROTOR_R(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .eif      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [4:0] key_i;
        logic       chk_lamp;
        logic [4:0] lamp_i;
        logic [4:0] l, m, r;
    } vec_t;

    vec_t tab_a[5];
    vec_t tab_ds[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] oh(input logic [4:0] i);
        return 26'd1 << i;
    endfunction

    function automatic logic [14:0] pos3();
        return {bus.pos_left, bus.pos_mid, bus.pos_right};
    endfunction

    task automatic strobe_key(input logic [25:0] k);
        @(negedge CLOCK_50);
        bus.key       = k;
        bus.key_valid = 1'b1;
        @(negedge CLOCK_50);
        bus.key_valid = 1'b0;
    endtask

    task automatic run_key(input logic [25:0] k, output logic [25:0] lo, output int lat);
        strobe_key(k);
        lat = -1;
        lo  = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLOCK_50);
            if (bus.lamp_valid) begin
                lat = n;
                lo  = bus.lamp;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
        @(negedge CLOCK_50);
        bus.load_en    = 1'b1;
        bus.load_left  = l;
        bus.load_mid   = m;
        bus.load_right = r;
        @(negedge CLOCK_50);
        bus.load_en = 1'b0;
    endtask

    initial begin
        logic [25:0] lo, lamp_before;
        logic [14:0] pos_before;
        int          lat, pulses, first_n, busy_seen;
        logic        ok;

        bus.key = '0; bus.key_valid = 1'b0; bus.load_en = 1'b0;
        bus.load_left = '0; bus.load_mid = '0; bus.load_right = '0;

        tab_a[0] = '{5'd0, 1'b1, 5'd1,  5'd0, 5'd0, 5'd1};
        tab_a[1] = '{5'd0, 1'b1, 5'd3,  5'd0, 5'd0, 5'd2};
        tab_a[2] = '{5'd0, 1'b1, 5'd25, 5'd0, 5'd0, 5'd3};
        tab_a[3] = '{5'd0, 1'b1, 5'd6,  5'd0, 5'd0, 5'd4};
        tab_a[4] = '{5'd0, 1'b1, 5'd14, 5'd0, 5'd0, 5'd5};
        tab_ds[0] = '{5'd0, 1'b0, 5'd0, 5'd0, 5'd3, 5'd21};
        tab_ds[1] = '{5'd0, 1'b0, 5'd0, 5'd0, 5'd4, 5'd22};
        tab_ds[2] = '{5'd0, 1'b0, 5'd0, 5'd1, 5'd5, 5'd23};

        repeat (3) @(negedge CLOCK_50);
        check("reset_busy", bus.busy, 0);
        check("reset_lamp", bus.lamp, 0);
        check("reset_lamp_valid", bus.lamp_valid, 0);
        check("reset_pos", pos3(), 0);
        resetn = 1'b1;

        foreach (tab_a[i]) begin
            run_key(oh(tab_a[i].key_i), lo, lat);
            check($sformatf("aaaaa_lamp%0d", i), lo, oh(tab_a[i].lamp_i));
            check($sformatf("aaaaa_lat%0d", i), lat, 9);
            check($sformatf("aaaaa_pos%0d", i), pos3(), {tab_a[i].l, tab_a[i].m, tab_a[i].r});
            check($sformatf("aaaaa_busy%0d", i), bus.busy, 0);
        end
        @(negedge CLOCK_50);
        check("lamp_valid_single", bus.lamp_valid, 0);
        check("lamp_hold", bus.lamp, oh(5'd14));

        do_load(5'd0, 5'd0, 5'd0);
        check("load_aaa", pos3(), 0);
        run_key(oh(5'd1), lo, lat);
        check("key_b_lamp", lo, oh(5'd0));
        do_load(5'd0, 5'd0, 5'd0);
        run_key(oh(5'd0), lo, lat);
        check("reciprocal", lo, oh(5'd1));

        do_load(5'd0, 5'd0, 5'd0);
        ok = 1'b1;
        for (int i = 0; i < 26; i++) begin
            run_key(oh(5'(i)), lo, lat);
            if (lo == oh(5'(i)) || !$onehot(lo) || lat != 9) ok = 1'b0;
        end
        check("never_self", ok, 1);
        check("pos_after_26", pos3(), {5'd0, 5'd1, 5'd0});

        do_load(5'd27, 5'd30, 5'd26);
        check("load_reduce", pos3(), {5'd1, 5'd4, 5'd0});

        // Load and key in the same idle cycle: load wins, key dropped.
        @(negedge CLOCK_50);
        bus.load_en = 1'b1; bus.load_left = 5'd2; bus.load_mid = 5'd2; bus.load_right = 5'd2;
        bus.key = oh(5'd0); bus.key_valid = 1'b1;
        @(negedge CLOCK_50);
        bus.load_en = 1'b0; bus.key_valid = 1'b0;
        busy_seen = 0;
        repeat (3) begin @(negedge CLOCK_50); if (bus.busy) busy_seen++; end
        check("load_wins_busy", busy_seen, 0);
        check("load_wins_pos", pos3(), {5'd2, 5'd2, 5'd2});

        do_load(5'd0, 5'd3, 5'd20);
        foreach (tab_ds[i]) begin
            run_key(oh(tab_ds[i].key_i), lo, lat);
            check($sformatf("dstep_pos%0d", i), pos3(), {tab_ds[i].l, tab_ds[i].m, tab_ds[i].r});
            check($sformatf("dstep_noself%0d", i), (lo != oh(tab_ds[i].key_i)) && $onehot(lo), 1);
        end

        lamp_before = bus.lamp;
        pos_before  = pos3();
        busy_seen   = 0;
        strobe_key(26'h0000003);
        repeat (3) begin @(negedge CLOCK_50); if (bus.busy) busy_seen++; end
        strobe_key(26'h0000000);
        repeat (3) begin @(negedge CLOCK_50); if (bus.busy) busy_seen++; end
        check("nonhot_busy", busy_seen, 0);
        check("nonhot_lamp", bus.lamp, lamp_before);
        check("nonhot_pos", pos3(), pos_before);

        // Key during BWD_M and load during FWD_L must both be ignored.
        do_load(5'd0, 5'd0, 5'd0);
        strobe_key(oh(5'd0));
        pulses = 0; first_n = -1; lo = '0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge CLOCK_50);
            if (bus.lamp_valid) begin
                pulses++;
                if (first_n < 0) begin first_n = n; lo = bus.lamp; end
            end
            if (n == 3) begin
                bus.load_en = 1'b1; bus.load_left = 5'd5; bus.load_mid = 5'd5; bus.load_right = 5'd5;
            end
            if (n == 4) bus.load_en = 1'b0;
            if (n == 6) begin bus.key = oh(5'd2); bus.key_valid = 1'b1; end
            if (n == 7) bus.key_valid = 1'b0;
        end
        check("busy_ign_pulses", pulses, 1);
        check("busy_ign_latency", first_n, 9);
        check("busy_ign_lamp", lo, oh(5'd1));
        check("busy_ign_pos", pos3(), {5'd0, 5'd0, 5'd1});
        check("busy_ign_idle", bus.busy, 0);

        do_load(5'd3, 5'd4, 5'd5);
        strobe_key(oh(5'd0));
        repeat (4) @(negedge CLOCK_50);
        #3 resetn = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_lamp", bus.lamp, 0);
        check("arst_pos", pos3(), 0);
        check("arst_lamp_valid", bus.lamp_valid, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        pulses = 0;
        repeat (12) begin @(negedge CLOCK_50); if (bus.lamp_valid) pulses++; end
        check("arst_no_partial", pulses, 0);
        run_key(oh(5'd0), lo, lat);
        check("post_rst_lamp", lo, oh(5'd1));
        check("post_rst_lat", lat, 9);
        check("post_rst_pos", pos3(), {5'd0, 5'd0, 5'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
